// File: rtl/fpu_issue_pkg.sv
// Shared types for the half-precision FPU issue block: operation encoding,
// queued request record, FSM states and flag/exception bit positions.
package fpu_issue_pkg;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      MUL = 2'b10,
      DIV = 2'b11
   } fpu_op_t;

   typedef struct packed {
      logic [15:0] opA;
      logic [15:0] opB;
      fpu_op_t     op;
   } fpu_req_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_O = 0;

   localparam int EXC_OVF = 2;
   localparam int EXC_UNF = 1;
   localparam int EXC_INX = 0;

endpackage

// File: rtl/fpu_issue_fpu.sv
// Combinational binary16 add/sub/mul/div. Subnormal inputs read as zero, tiny
// results flush to zero, rounding is nearest-even, any Inf/NaN input yields qNaN.
module fpu_issue_fpu
   import fpu_issue_pkg::*;
(
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  fpu_op_t     op_i,
   output logic [15:0] result_o,
   output logic [3:0]  flags_o,
   output logic [2:0]  exc_o
);

   // m holds {hidden, 10 fraction, guard, round, sticky}; returns {result, exc}.
   function automatic logic [18:0] round_pack(input logic s, input logic signed [7:0] e,
                                              input logic [13:0] m);
      logic        inc;
      logic [14:0] body;
      inc  = m[2] & (m[3] | m[1] | m[0]);
      body = {e[4:0], m[12:3]} + {14'd0, inc};
      if (m == 14'd0)
         round_pack = {s, 15'd0, 3'b000};
      else if (e <= 8'sd0)
         round_pack = {s, 15'd0, 3'b011};
      else if (e >= 8'sd31 || body[14:10] == 5'h1f)
         round_pack = {s, 15'h7C00, 3'b100};
      else
         round_pack = {s, body, 2'b00, |m[2:0]};
   endfunction

   function automatic logic [3:0] lzc14(input logic [13:0] v);
      lzc14 = 4'd14;
      for (int i = 0; i < 14; i++)
         if (v[i]) lzc14 = 4'(13 - i);
   endfunction

   logic              sa, sb, za, zb, sb_eff, swap, big_s, sm_s, eff_sub, carry, s_out, nan;
   logic [4:0]        ea, eb, big_e, sm_e, diff;
   logic [10:0]       ma, mb, big_m, sm_m, divisor, rem;
   logic [27:0]       sh;
   logic [13:0]       mx, my, m, q;
   logic [14:0]       sum;
   logic [3:0]        lz;
   logic [21:0]       p;
   logic [23:0]       num;
   logic signed [7:0] e;
   logic [18:0]       pk;

   always_comb begin
      sa      = a_i[15];
      sb      = b_i[15];
      ea      = a_i[14:10];
      eb      = b_i[14:10];
      za      = (ea == 5'd0);
      zb      = (eb == 5'd0);
      ma      = za ? 11'd0 : {1'b1, a_i[9:0]};
      mb      = zb ? 11'd0 : {1'b1, b_i[9:0]};
      nan     = (ea == 5'h1f) || (eb == 5'h1f);
      sb_eff  = sb ^ (op_i == SUB);
      swap    = a_i[14:0] < b_i[14:0];
      big_s   = swap ? sb_eff : sa;
      sm_s    = swap ? sa : sb_eff;
      big_e   = swap ? eb : ea;
      sm_e    = swap ? ea : eb;
      big_m   = swap ? mb : ma;
      sm_m    = swap ? ma : mb;
      diff    = big_e - sm_e;
      sh      = {sm_m, 17'd0} >> diff;
      mx      = {big_m, 3'b000};
      my      = sh[27:14] | {13'd0, |sh[13:0]};
      eff_sub = big_s ^ sm_s;
      sum     = eff_sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
      lz      = lzc14(sum[13:0]);
      p       = ma * mb;
      divisor = zb ? 11'd1 : mb;
      num     = {ma, 13'd0};
      q       = 14'(num / {13'd0, divisor});
      rem     = 11'(num % {13'd0, divisor});
      carry   = 1'b0;
      s_out   = 1'b0;
      m       = 14'd0;
      e       = 8'sd0;
      case (op_i)
         ADD, SUB: begin
            carry = sum[14] & ~eff_sub;
            s_out = (sum == 15'd0) ? 1'b0 : big_s;
            if (sum[14]) begin
               m = {sum[14:2], |sum[1:0]};
               e = $signed({3'b000, big_e}) + 8'sd1;
            end else begin
               m = sum[13:0] << lz;
               e = $signed({3'b000, big_e}) - $signed({4'b0000, lz});
            end
         end
         MUL: begin
            s_out = sa ^ sb;
            e     = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;
            if (p[21]) begin
               m = {p[21:9], |p[8:0]};
               e = e + 8'sd1;
            end else begin
               m = {p[20:8], |p[7:0]};
            end
         end
         default: begin
            s_out = sa ^ sb;
            e     = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 8'sd15;
            if (q[13]) begin
               m = {q[13:1], q[0] | (rem != 11'd0)};
            end else begin
               m = {q[12:0], rem != 11'd0};
               e = e - 8'sd1;
            end
         end
      endcase
      pk       = round_pack(s_out, e, m);
      result_o = pk[18:3];
      exc_o    = pk[2:0];
      // Divide by zero returns signed infinity and is reported as overflow.
      if (op_i == DIV && zb) begin
         result_o = za ? 16'h7E00 : {s_out, 15'h7C00};
         exc_o    = za ? 3'b000 : 3'b100;
      end
      if (nan) begin
         result_o = 16'h7E00;
         exc_o    = 3'b000;
      end
      flags_o         = 4'd0;
      flags_o[FLAG_N] = result_o[15];
      flags_o[FLAG_Z] = (result_o[14:0] == 15'd0);
      flags_o[FLAG_C] = carry;
      flags_o[FLAG_O] = exc_o[EXC_OVF];
   end

endmodule

// File: rtl/fpu_issue.sv
// Request queue in front of a single FPU: holds operands for EXEC_CYCLES,
// captures result/flags/exceptions and presents them until the consumer accepts.
module fpu_issue
   import fpu_issue_pkg::*;
#(
   parameter int EXEC_CYCLES = 2,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_opA,
   input  logic [15:0] req_opB,
   input  logic [1:0]  req_op,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic [2:0]  rsp_exc,
   output logic [2:0]  sticky_exc,
   input  logic        sticky_clr,
   output logic        busy
);

   localparam int         PTR_W     = $clog2(FIFO_DEPTH);
   localparam int         CNT_W     = PTR_W + 1;
   localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

   fpu_req_t         mem_q [FIFO_DEPTH];
   fpu_req_t         opnd_q;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full, empty, push, pop, capture;
   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [15:0]      fpu_result, rsp_result_q;
   logic [3:0]       fpu_flags, rsp_flags_q;
   logic [2:0]       fpu_exc, rsp_exc_q, sticky_q, sticky_d;

   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign req_ready = !full;
   assign push      = req_valid && !full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage carries no reset; occupancy and state alone decide validity.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= '{opA: req_opA, opB: req_opB, op: fpu_op_t'(req_op)};
      if (pop)  opnd_q <= mem_q[rd_ptr_q];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_EXEC;
               cnt_d   = EXEC_LOAD;
            end
         end
         S_EXEC: begin
            if (cnt_q == 4'd0) begin
               capture = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = S_EXEC;
                  cnt_d   = EXEC_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      sticky_d = sticky_q;
      if (capture)
         sticky_d = (sticky_clr ? 3'b000 : sticky_q) | fpu_exc;
      else if (sticky_clr)
         sticky_d = 3'b000;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         rsp_result_q <= 16'd0;
         rsp_flags_q  <= 4'd0;
         rsp_exc_q    <= 3'd0;
         sticky_q     <= 3'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         if (capture) begin
            rsp_result_q <= fpu_result;
            rsp_flags_q  <= fpu_flags;
            rsp_exc_q    <= fpu_exc;
         end
      end
   end

   fpu_issue_fpu u_fpu (
      .a_i      (opnd_q.opA),
      .b_i      (opnd_q.opB),
      .op_i     (opnd_q.op),
      .result_o (fpu_result),
      .flags_o  (fpu_flags),
      .exc_o    (fpu_exc)
   );

   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign rsp_exc    = rsp_exc_q;
   assign sticky_exc = sticky_q;
   assign busy       = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_issue.sv
// Table-driven bench for fpu_issue with an in-order scoreboard of expected
// {result, flags, exceptions}, plus sequences for latency, sticky, stall and reset.
module tb_fpu_issue;
   import fpu_issue_pkg::*;

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  flags;
      logic [2:0]  exc;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      exp_t        e;
   } vec_t;

   logic        clk, reset, req_valid, req_ready, rsp_valid, rsp_ready, sticky_clr, busy;
   logic [15:0] req_opA, req_opB, rsp_result;
   logic [1:0]  req_op;
   logic [3:0]  rsp_flags;
   logic [2:0]  rsp_exc, sticky_exc;

   exp_t sb_q[$];
   exp_t cur_exp, mon_e;
   vec_t tbl[12];
   int   n_cmp = 0;
   int   n_fail = 0;

   fpu_issue #(.EXEC_CYCLES(2), .FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_opA(req_opA), .req_opB(req_opB), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_exc(rsp_exc), .sticky_exc(sticky_exc),
      .sticky_clr(sticky_clr), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (req_valid && req_ready) sb_q.push_back(cur_exp);
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL rsp_unexpected: got result 0x%h, expected no response", rsp_result);
            end else begin
               mon_e = sb_q.pop_front();
               check("rsp_result", 32'(rsp_result), 32'(mon_e.res));
               check("rsp_flags", 32'(rsp_flags), 32'(mon_e.flags));
               check("rsp_exc", 32'(rsp_exc), 32'(mon_e.exc));
            end
         end
      end
   end

   task automatic send(input vec_t v);
      int  guard;
      logic ok;
      req_valid = 1'b1;
      req_opA   = v.a;
      req_opB   = v.b;
      req_op    = v.op;
      cur_exp   = v.e;
      guard     = 0;
      ok        = 1'b0;
      while (!ok && guard < 200) begin
         @(negedge clk);
         ok = req_ready;
         guard++;
      end
      check("send_accept", 32'(ok), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while ((busy || sb_q.size() != 0) && g < 300) begin
         @(posedge clk);
         #1 g++;
      end
      check("drain_timeout", 32'(g >= 300), 32'd0);
   endtask

   task automatic pulse_clr();
      sticky_clr = 1'b1;
      @(posedge clk);
      #1 sticky_clr = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
      check({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
      check({tag, "_rsp_exc"}, 32'(rsp_exc), 32'd0);
      check({tag, "_sticky"}, 32'(sticky_exc), 32'd0);
   endtask

   initial begin
      int   lat;
      logic saw;
      reset = 1'b1; req_valid = 1'b0; req_opA = '0; req_opB = '0; req_op = '0;
      rsp_ready = 1'b1; sticky_clr = 1'b0; cur_exp = '0;

      //          opA       opB      op     {result,  NZCO,    ovf/unf/inx}
      tbl[0]  = '{16'h3C00, 16'h4000, 2'b00, {16'h4200, 4'b0000, 3'b000}};
      tbl[1]  = '{16'h3C00, 16'h3C00, 2'b01, {16'h0000, 4'b0100, 3'b000}};
      tbl[2]  = '{16'h4000, 16'h4200, 2'b10, {16'h4600, 4'b0000, 3'b000}};
      tbl[3]  = '{16'h7BFF, 16'h7BFF, 2'b10, {16'h7C00, 4'b0001, 3'b100}};
      tbl[4]  = '{16'h3C00, 16'h3C00, 2'b00, {16'h4000, 4'b0010, 3'b000}};
      tbl[5]  = '{16'h4200, 16'h4000, 2'b11, {16'h3E00, 4'b0000, 3'b000}};
      tbl[6]  = '{16'h3C00, 16'h4000, 2'b01, {16'hBC00, 4'b1000, 3'b000}};
      tbl[7]  = '{16'h3C00, 16'h0000, 2'b10, {16'h0000, 4'b0100, 3'b000}};
      tbl[8]  = '{16'h3C00, 16'h4200, 2'b11, {16'h3555, 4'b0000, 3'b001}};
      tbl[9]  = '{16'h3C00, 16'h0000, 2'b11, {16'h7C00, 4'b0001, 3'b100}};
      tbl[10] = '{16'h0401, 16'h0400, 2'b01, {16'h0000, 4'b0100, 3'b011}};
      tbl[11] = '{16'h3C01, 16'h3C01, 2'b10, {16'h3C02, 4'b0000, 3'b001}};

      repeat (3) @(posedge clk);
      #1 check_reset_vals("rst");
      reset = 1'b0;

      // First request on the first edge after release; result three edges later.
      send(tbl[0]);
      lat = 0;
      forever begin
         @(negedge clk);
         if (rsp_valid || lat >= 20) break;
         lat++;
      end
      check("latency", 32'(lat), 32'd3);
      wait_idle();

      for (int i = 0; i < 12; i++) send(tbl[i]);
      wait_idle();

      pulse_clr();
      check("sticky_clr0", 32'(sticky_exc), 32'd0);
      send(tbl[3]);
      wait_idle();
      check("sticky_ovf", 32'(sticky_exc), 32'b100);
      send(tbl[4]);
      wait_idle();
      check("sticky_persist", 32'(sticky_exc), 32'b100);
      pulse_clr();
      check("sticky_clr1", 32'(sticky_exc), 32'd0);
      send(tbl[8]);
      wait_idle();
      check("sticky_inx", 32'(sticky_exc), 32'b001);
      send(tbl[3]);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 sticky_clr = 1'b1;
      @(posedge clk);
      #1 sticky_clr = 1'b0;
      check("sticky_clr_on_capture", 32'(sticky_exc), 32'b100);
      wait_idle();

      rsp_ready = 1'b0;
      fork
         begin
            send(tbl[0]);
            send(tbl[2]);
            send(tbl[5]);
            send(tbl[6]);
         end
         begin
            repeat (12) @(posedge clk);
            #1;
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_rsp_held", 32'(rsp_result), 32'h4200);
            rsp_ready = 1'b1;
         end
      join
      wait_idle();

      send(tbl[0]);
      send(tbl[2]);
      send(tbl[5]);
      reset = 1'b1;
      #1 check_reset_vals("midexec");
      sb_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         saw = saw | rsp_valid;
      end
      check("stale_rsp", 32'(saw), 32'd0);
      send(tbl[1]);
      wait_idle();
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
